// File: rtl/bcd_to_7seg_pkg.sv
// Shared constants for the BCD digit counter and its seven-segment encoder.
// Segment bit order: bit7 = dp, bit6 = g, ..., bit0 = a (lit when 1).
package bcd_to_7seg_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 8;

  // Largest legal BCD digit; the counter wraps to 0 after it.
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  // Common-cathode patterns for digits 0-9 (dp always unlit).
  localparam logic [SEG_W-1:0] SEG_0     = 8'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 8'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 8'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 8'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 8'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h6F;
  // Shown for any non-BCD value so a corrupted register is visibly blank.
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;

  // Lit-when-1 pattern for one digit; codes 10-15 map to blank.
  function automatic logic [SEG_W-1:0] seg_code(input logic [DIGIT_W-1:0] digit);
    logic [SEG_W-1:0] code;
    code = SEG_BLANK;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bcd_to_7seg_bcd_seg_decoder.sv
// Combinational BCD digit to seven-segment (plus dp) encoder.
// SEG_ACTIVE_LOW = 1 inverts every output bit, dp included, for common-anode parts.
module bcd_seg_decoder
  import bcd_to_7seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   pattern
);

  logic [SEG_W-1:0] raw;

  // Look up the lit-when-1 pattern, then apply the display polarity.
  always_comb begin
    raw     = seg_code(digit);
    pattern = SEG_ACTIVE_LOW ? ~raw : raw;
  end

endmodule

// File: rtl/bcd_to_7seg.sv
// Single-digit decimal counter with parallel load and seven-segment output.
// Priority on each rising edge: reset > Load > increment (9 wraps to 0).
// Q_out decodes only the count register, so Load/Din never reach it combinationally.
module bcd_to_7seg
  import bcd_to_7seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Load,
  input  logic [DIGIT_W-1:0] Din,
  output logic [SEG_W-1:0]   Q_out
);

  logic [DIGIT_W-1:0] count;
  logic [DIGIT_W-1:0] count_next;

  // Next count: load a legal digit (non-BCD loads 0), else step with wrap.
  // Any value >= 9 steps to 0 so an illegal register value recovers in one edge.
  always_comb begin
    count_next = '0;
    if (Load) begin
      count_next = (Din > DIGIT_MAX) ? '0 : Din;
    end else if (count >= DIGIT_MAX) begin
      count_next = '0;
    end else begin
      count_next = count + 4'd1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  bcd_seg_decoder #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_decoder (
    .digit  (count),
    .pattern(Q_out)
  );

endmodule

// File: tb/tb_bcd_to_7seg.sv
// Directed bench for bcd_to_7seg: two instances share the stimulus, one per
// display polarity, and each scenario task checks its own expected patterns.
module tb_bcd_to_7seg;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] din;
  logic [7:0] q_cc;   // common-cathode instance
  logic [7:0] q_ca;   // common-anode instance

  int checks;
  int errors;

  logic [7:0] exp_q[$];

  bcd_to_7seg #(.SEG_ACTIVE_LOW(1'b0)) dut_cc (
    .clk  (clk),
    .rst_n(rst_n),
    .Load (load),
    .Din  (din),
    .Q_out(q_cc)
  );

  bcd_to_7seg #(.SEG_ACTIVE_LOW(1'b1)) dut_ca (
    .clk  (clk),
    .rst_n(rst_n),
    .Load (load),
    .Din  (din),
    .Q_out(q_ca)
  );

  // Clock and initial input levels.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; din = 4'd0;
    step();
    checks++;
    if (q_cc !== 8'h3F) begin
      errors++;
      $display("FAIL reset_cc: got %h expected %h", q_cc, 8'h3F);
    end
    checks++;
    if (q_ca !== 8'hC0) begin
      errors++;
      $display("FAIL reset_ca: got %h expected %h", q_ca, 8'hC0);
    end
  endtask

  // Release reset and walk the full 10-step cycle back to 0.
  task automatic test_count();
    logic [7:0] e;
    exp_q = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h3F};
    rst_n = 1'b1; load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din = 4'($urandom_range(0, 15));  // ignored while Load is low
      step();
      e = exp_q.pop_front();
      checks++;
      if (q_cc !== e) begin
        errors++;
        $display("FAIL count_step%0d: got %h expected %h", i + 1, q_cc, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (q_cc !== 8'h07) begin
      errors++;
      $display("FAIL mid_at7: got %h expected %h", q_cc, 8'h07);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (q_cc !== 8'h3F) begin
      errors++;
      $display("FAIL mid_reset: got %h expected %h", q_cc, 8'h3F);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (q_cc !== 8'h06) begin
      errors++;
      $display("FAIL mid_release: got %h expected %h", q_cc, 8'h06);
    end
  endtask

  task automatic test_load();
    din = 4'd5; load = 1'b1;
    step();
    checks++;
    if (q_cc !== 8'h6D) begin
      errors++;
      $display("FAIL load5: got %h expected %h", q_cc, 8'h6D);
    end
    // Output must not react to Load/Din between edges.
    load = 1'b1; din = 4'd1;
    #2;
    checks++;
    if (q_cc !== 8'h6D) begin
      errors++;
      $display("FAIL load_no_comb: got %h expected %h", q_cc, 8'h6D);
    end
    load = 1'b0; din = 4'd2;
    step();
    checks++;
    if (q_cc !== 8'h7D) begin
      errors++;
      $display("FAIL load_inc6: got %h expected %h", q_cc, 8'h7D);
    end
    step();
    checks++;
    if (q_cc !== 8'h07) begin
      errors++;
      $display("FAIL load_inc7: got %h expected %h", q_cc, 8'h07);
    end
  endtask

  task automatic test_load_wrap();
    din = 4'd9; load = 1'b1;
    step();
    checks++;
    if (q_cc !== 8'h6F) begin
      errors++;
      $display("FAIL load9: got %h expected %h", q_cc, 8'h6F);
    end
    din = 4'd3;
    step();
    checks++;
    if (q_cc !== 8'h4F) begin
      errors++;
      $display("FAIL load_over_wrap: got %h expected %h", q_cc, 8'h4F);
    end
    load = 1'b0;
  endtask

  task automatic test_invalid_load();
    logic [3:0] bad[3];
    bad = '{4'd12, 4'd10, 4'd15};
    for (int i = 0; i < 3; i++) begin
      load = 1'b1; din = 4'd4;
      step();
      din = bad[i];
      step();
      checks++;
      if (q_cc !== 8'h3F) begin
        errors++;
        $display("FAIL invalid_load_%0d: got %h expected %h", bad[i], q_cc, 8'h3F);
      end
    end
    load = 1'b1; din = 4'd7;
    step();
    rst_n = 1'b0; load = 1'b1; din = 4'd5;
    step();
    checks++;
    if (q_cc !== 8'h3F) begin
      errors++;
      $display("FAIL reset_over_load: got %h expected %h", q_cc, 8'h3F);
    end
    rst_n = 1'b1; load = 1'b0;
    step();
    checks++;
    if (q_cc !== 8'h06) begin
      errors++;
      $display("FAIL after_reset_load: got %h expected %h", q_cc, 8'h06);
    end
  endtask

  task automatic test_active_low();
    rst_n = 1'b0; load = 1'b0;
    step();
    checks++;
    if (q_ca !== 8'hC0) begin
      errors++;
      $display("FAIL ca_reset: got %h expected %h", q_ca, 8'hC0);
    end
    rst_n = 1'b1; load = 1'b1; din = 4'd8;
    step();
    checks++;
    if (q_ca !== 8'h80) begin
      errors++;
      $display("FAIL ca_load8: got %h expected %h", q_ca, 8'h80);
    end
    load = 1'b0;
    step();
    checks++;
    if (q_ca !== 8'h90) begin
      errors++;
      $display("FAIL ca_inc9: got %h expected %h", q_ca, 8'h90);
    end
    step();
    checks++;
    if (q_ca !== 8'hC0) begin
      errors++;
      $display("FAIL ca_wrap: got %h expected %h", q_ca, 8'hC0);
    end
    load = 1'b1; din = 4'd1;
    step();
    checks++;
    if (q_ca !== 8'hF9) begin
      errors++;
      $display("FAIL ca_load1: got %h expected %h", q_ca, 8'hF9);
    end
    load = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    load   = 1'b0;
    din    = 4'd0;
    #1;
    test_reset();
    test_count();
    test_reset_mid();
    test_load();
    test_load_wrap();
    test_invalid_load();
    test_active_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
